// File: rtl/nes_pad_pkg.sv
// Shared FSM state type and button bit indices for the NES/SNES multi-pad reader.
// PAD_PRESENCE_EN selects one extra presence-detect clock pulse per frame.
package nes_pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_DONE
    } pad_state_e;

    localparam int NES_A      = 0;
    localparam int NES_B      = 1;
    localparam int NES_SELECT = 2;
    localparam int NES_START  = 3;
    localparam int NES_UP     = 4;
    localparam int NES_DOWN   = 5;
    localparam int NES_LEFT   = 6;
    localparam int NES_RIGHT  = 7;

    localparam int SNES_B      = 0;
    localparam int SNES_Y      = 1;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;
    localparam int SNES_X      = 9;
    localparam int SNES_L      = 10;
    localparam int SNES_R      = 11;

`ifdef PAD_PRESENCE_EN
    localparam int PRESENCE_PULSES = 1;
`else
    localparam int PRESENCE_PULSES = 0;
`endif

endpackage

// File: rtl/nes_pad_lane.sv
// One pad's data path: 2-flop synchroniser on the serial line feeding a shift register.
// Bits enter at the top and move down, so the first bit shifted lands in frame[0].
module nes_pad_lane #(
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               pad_data,
    input  logic               sample_en,
    output logic [FRAME_W-1:0] frame
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        sync_p0 <= pad_data;
        sync_p1 <= sync_p0;
        if (sample_en) begin
            frame <= {sync_p1, frame[FRAME_W-1:1]};
        end
    end

endmodule

// File: rtl/nes_multi_pad_reader.sv
// Multi-pad NES/SNES serial gamepad reader: shared latch/clock, parallel data lanes,
// auto-polling and a valid strobe. Optional macro: PAD_PRESENCE_EN (presence detection).
module nes_multi_pad_reader
    import nes_pad_pkg::*;
#(
    parameter int N_PADS       = 2,
    parameter int N_BITS       = 8,
    parameter int CLK_DIV      = 384,
    parameter int LATCH_CYCLES = 768,
    parameter int POLL_CYCLES  = 1066666
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     auto_en,
    input  logic [N_PADS-1:0]        pad_data,
    output logic                     pad_latch,
    output logic                     pad_clk,
    output logic [N_PADS*N_BITS-1:0] buttons,
    output logic [N_PADS-1:0]        present,
    output logic                     busy,
    output logic                     valid
);

    localparam int PULSES  = N_BITS - 1 + PRESENCE_PULSES;
    localparam int FRAME_W = N_BITS + PRESENCE_PULSES;
    localparam int PH_MAX  = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
    localparam int PH_W    = $clog2(PH_MAX);
    localparam int BC_W    = $clog2(PULSES + 1);
    localparam int PC_W    = $clog2(POLL_CYCLES);

    localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] PULSE_LAST = BC_W'(PULSES - 1);
    localparam logic [PC_W-1:0] POLL_LAST  = PC_W'(POLL_CYCLES - 1);

    pad_state_e                  state;
    pad_state_e                  next_state;
    logic [PH_W-1:0]             phase;
    logic [BC_W-1:0]             bit_cnt;
    logic [PC_W-1:0]             poll_cnt;
    logic                        latch_done;
    logic                        half_done;
    logic                        trigger;
    logic                        sample_en;
    logic [N_PADS*FRAME_W-1:0]   frames;
    logic [N_PADS*N_BITS-1:0]    buttons_next;
    logic [N_PADS-1:0]           present_next;

    assign latch_done = (phase == LATCH_LAST);
    assign half_done  = (phase == HALF_LAST);
    // A poll wrap that lands while busy is simply lost; start and wrap together give one scan.
    assign trigger    = start | (auto_en & (poll_cnt == POLL_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (trigger)    next_state = ST_LATCH;
            ST_LATCH:    if (latch_done) next_state = ST_SHIFT_HI;
            ST_SHIFT_HI: if (half_done)  next_state = ST_SHIFT_LO;
            ST_SHIFT_LO: if (half_done)  next_state = (bit_cnt == PULSE_LAST) ? ST_DONE : ST_SHIFT_HI;
            ST_DONE:                     next_state = ST_IDLE;
            default:                     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        pad_latch = (state == ST_LATCH);
        pad_clk   = (state == ST_SHIFT_HI);
        busy      = (state != ST_IDLE);
        sample_en = ((state == ST_LATCH) && latch_done) || ((state == ST_SHIFT_LO) && half_done);
    end

    // Phase restarts on every state change so each state times its own dwell.
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE || state != next_state) begin
            phase <= '0;
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == ST_LATCH) begin
            bit_cnt <= '0;
        end else if (state == ST_SHIFT_LO && half_done) begin
            bit_cnt <= bit_cnt + BC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !auto_en || poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + PC_W'(1);
        end
    end

    for (genvar p = 0; p < N_PADS; p++) begin : g_lane
        nes_pad_lane #(
            .FRAME_W (FRAME_W)
        ) u_lane (
            .clk       (clk),
            .pad_data  (pad_data[p]),
            .sample_en (sample_en),
            .frame     (frames[p*FRAME_W +: FRAME_W])
        );
    end

    // Pad lines are active-low: a pressed button shifts out 0.
    always_comb begin
        buttons_next = '0;
        present_next = '0;
        for (int p = 0; p < N_PADS; p++) begin
            buttons_next[p*N_BITS +: N_BITS] = ~frames[p*FRAME_W +: N_BITS];
`ifdef PAD_PRESENCE_EN
            present_next[p] = ~frames[p*FRAME_W + N_BITS];
`else
            present_next[p] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buttons <= '0;
            present <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                buttons <= buttons_next;
                present <= present_next;
            end
        end
    end

endmodule
